// File: rtl/pipeline_output_buffer_if.sv
// Handshake bundle between the upstream shift pipeline, the output buffer and its consumer.
// The slave modport is the buffer's view; the master modport is the surrounding environment.
interface pipeline_output_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [7:0]       accepted;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output count,
    output overflow,
    output accepted
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  count,
    input  overflow,
    input  accepted
  );
endinterface

// File: rtl/pipeline_output_buffer.sv
// First-word fall-through output buffer for the 4-stage shift pipeline.
// Writes are refused while full (sticky overflow flag records the drop); in_ready depends only
// on registered occupancy so there is no combinational path from out_ready back upstream.
module pipeline_output_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_output_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       accepted_q, accepted_d;

  logic in_ready, out_valid, wr_en, rd_en;

  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign wr_en     = bus.in_valid & in_ready;
  assign rd_en     = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.accepted  = accepted_q;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;

    if (wr_en) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      accepted_d = accepted_q + 8'd1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A write presented while full is dropped, even if a read frees a slot this cycle.
    if (bus.in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset that overrides any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      accepted_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      accepted_q <= accepted_d;
    end
  end

  // Storage array; contents are don't-care after reset, so it is not cleared.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipeline_output_buffer.sv
// Self-checking bench for pipeline_output_buffer using a queue-based reference model.
module tb_pipeline_output_buffer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic reset;

  pipeline_output_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipeline_output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a bounded FIFO of bytes plus the two status values.
  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_acc;

  // Advance the model by one clock using the inputs currently driven, then let the DUT clock.
  task automatic tick();
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_acc = 0;
    end else begin
      bit full;
      bit w;
      bit r;
      full = (m_q.size() == DEPTH);
      w    = bus.in_valid && !full;
      r    = bus.out_ready && (m_q.size() > 0);
      if (bus.in_valid && full) m_ovf = 1'b1;
      if (r) void'(m_q.pop_front());
      if (w) begin
        m_q.push_back(bus.in_data);
        m_acc = (m_acc + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b0;
    tick();
    tick();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.accepted !== 8'd0) begin bad++; $display("FAIL reset_accepted got=%0d want=0", bus.accepted); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
    reset        = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_in_order();
    logic [7:0] pat [4];
    pat[0] = 8'hCC; pat[1] = 8'hAA; pat[2] = 8'hF0; pat[3] = 8'h0F;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = pat[i];
      tick();
      total++; if (bus.count !== CW'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d want=%0d", bus.count, i + 1); end
    end
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready); end
    // Head must hold steady while stalled.
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.out_data !== 8'hCC) begin bad++; $display("FAIL stall_hold got=%h want=cc", bus.out_data); end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== pat[i]) begin
        bad++; $display("FAIL drain_data got=%b/%h want=1/%h", bus.out_valid, bus.out_data, pat[i]);
      end
      tick();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", bus.out_valid); end
    // Reads while empty must not move anything.
    tick();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL empty_read_count got=%0d want=0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'h11 * (i + 1));
      tick();
    end
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (bus.count !== CW'(3)) begin bad++; $display("FAIL ovf_count got=%0d want=3", bus.count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", bus.overflow); end
    total++; if (bus.accepted !== 8'd4) begin bad++; $display("FAIL ovf_accepted got=%0d want=4", bus.accepted); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_data !== m_q[0]) begin bad++; $display("FAIL ovf_drain got=%h want=%h", bus.out_data, m_q[0]); end
      tick();
    end
    bus.out_ready = 1'b0;
    tick();
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA1; tick();
    bus.in_data = 8'hA2; tick();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.in_data = 8'(i);
      total++; if (bus.out_data !== m_q[0]) begin bad++; $display("FAIL b2b_data got=%h want=%h", bus.out_data, m_q[0]); end
      tick();
      total++; if (bus.count !== CW'(2)) begin bad++; $display("FAIL b2b_count got=%0d want=2", bus.count); end
    end
    bus.in_valid = 1'b0;
    for (int i = 5; i <= 6; i++) begin
      total++; if (bus.out_data !== 8'(i)) begin bad++; $display("FAIL b2b_tail got=%h want=%h", bus.out_data, 8'(i)); end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (bus.count !== CW'(3) || bus.overflow !== 1'b1) begin
      bad++; $display("FAIL mid_setup got=%0d/%b want=3/1", bus.count, bus.overflow);
    end
    // Reset wins over a simultaneous write and read.
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h99;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL mid_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", bus.overflow); end
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      bad++; $display("FAIL mid_latency got=%b/%h want=1/3c", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_accept_wrap();
    do_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_data = 8'($urandom);
      if (m_q.size() > 0) begin
        total++; if (bus.out_data !== m_q[0]) begin bad++; $display("FAIL wrap_data got=%h want=%h", bus.out_data, m_q[0]); end
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (bus.accepted !== 8'd0) begin bad++; $display("FAIL wrap_accepted got=%0d want=0", bus.accepted); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%b want=0", bus.overflow); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 63) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      bus.in_data   = 8'($urandom);
      tick();
      total++; if (bus.count !== CW'(m_q.size())) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", bus.count, m_q.size()); end
      total++; if (bus.out_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_out_valid got=%b", bus.out_valid); end
      total++; if (bus.in_ready !== (m_q.size() != DEPTH)) begin bad++; $display("FAIL rnd_in_ready got=%b", bus.in_ready); end
      total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow got=%b want=%b", bus.overflow, m_ovf); end
      total++; if (bus.accepted !== 8'(m_acc)) begin bad++; $display("FAIL rnd_accepted got=%0d want=%0d", bus.accepted, m_acc); end
      if (m_q.size() > 0) begin
        total++; if (bus.out_data !== m_q[0]) begin bad++; $display("FAIL rnd_data got=%h want=%h", bus.out_data, m_q[0]); end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    m_ovf = 1'b0;
    m_acc = 0;
    test_reset();
    test_in_order();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_accept_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_output_buffer.md
PIPELINE_OUTPUT_BUFFER -- requirements
Module: pipeline_output_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; sampled only on the rising clk edge.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: the byte from the upstream 4-stage shift pipeline's data_out.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is presented for capture this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the buffer can accept a write this cycle.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: the oldest stored entry (head).
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: the current occupancy, 0..DEPTH.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-013 The block SHALL have port accepted, output, 8 bits: wrapping count of accepted writes.

Function
REQ-014 The block SHALL implement write = in_valid AND in_ready, and on a write store in_data at the write pointer and advance the pointer modulo DEPTH.
REQ-015 The block SHALL implement read = out_valid AND out_ready, and on a read advance the read pointer modulo DEPTH.
REQ-016 The block SHALL drive in_ready = (count != DEPTH), depending only on registered state, with no combinational path from out_ready.
REQ-017 The block SHALL drive out_valid = (count != 0) and out_data = mem[read pointer] as first-word fall-through, with no output register stage.
REQ-018 The block SHALL deliver write-to-read latency of 1 cycle: a byte written at edge N appears on out_data with out_valid high in the cycle after edge N.
REQ-019 The block SHALL update count per cycle as follows: write only gives +1; read only gives -1; write and read together leave count unchanged; neither leaves count unchanged.
REQ-020 The block SHALL handle simultaneous read and write with 0 < count < DEPTH by performing both and preserving order.
REQ-021 The block SHALL handle full (count = DEPTH) with in_valid = 1 as follows: no write, even if a read occurs that cycle; overflow set to 1 at the next edge; the data is dropped.
REQ-022 The block SHALL ignore out_ready when empty (count = 0): no pointer movement, count stays 0.
REQ-023 The block SHALL hold overflow at 1 until reset once it is set.
REQ-024 The block SHALL increment accepted by 1 on each write, wrapping 255 -> 0; dropped writes SHALL NOT count.
REQ-025 The block SHALL wrap pointers naturally at DEPTH and preserve data order across wrap.
REQ-026 The block SHALL hold out_data stable while out_valid = 1 and out_ready = 0.

Reset
REQ-027 The block SHALL, on reset = 0 at a rising edge, clear both pointers, count, overflow and accepted to 0; storage contents are don't-care.
REQ-028 The block SHALL hold the following values during and immediately after reset: out_valid = 0, in_ready = 1, count = 0, overflow = 0, accepted = 0.
REQ-029 The block SHALL let reset override any write or read in the same cycle, including reset asserted mid-stream with entries stored; all entries are discarded.
REQ-030 The block SHALL accept a write on the first edge with reset = 1.

Verification
REQ-031 The bench SHALL check reset values: hold reset = 0 for 2 edges with in_valid = 1 and in_data = 0xFF -> count = 0, out_valid = 0, in_ready = 1, accepted = 0.
REQ-032 The bench SHALL check in-order delivery: write 0xCC, 0xAA, 0xF0, 0x0F on consecutive cycles with out_ready = 0 -> count = 4, in_ready = 0; then out_ready = 1 -> out_data reads 0xCC, 0xAA, 0xF0, 0x0F on consecutive cycles, then out_valid = 0.
REQ-033 The bench SHALL check overflow: with the buffer full, present 0x55 with in_valid = 1 and out_ready = 1 -> one read, 0x55 dropped, overflow = 1 and stays 1, accepted = 4.
REQ-034 The bench SHALL check simultaneous read/write: with count = 2, drive in_valid = 1 and out_ready = 1 for 6 cycles with values 0x01..0x06 -> count stays 2, pointers wrap, output order is preserved.
REQ-035 The bench SHALL check reset mid-operation: with count = 3, assert reset = 0 for 1 edge -> count = 0, out_valid = 0, overflow = 0; a following write of 0x3C appears on out_data 1 cycle later.
REQ-036 The bench SHALL check accepted wrap: perform 256 accepted writes with continuous reads -> accepted returns to 0, overflow = 0.
